// File: rtl/i2c_codec_responder.sv
// Write-only I2C target emulating the codec control port; 3-byte writes commit {7b reg, 9b data} to a regfile.
// Bus events act 3 clk after the pin edge; no backpressure, the word is ACKed and committed unconditionally.
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         NUM_REGS = 16,
   parameter logic [6:0] RST_REG  = 7'h0F
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       busy,
   output logic       nack_evt
);

   localparam int AW = $clog2(NUM_REGS);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
   } state_t;

   typedef struct packed {
      logic [6:0] addr;
      logic [8:0] data;
   } word_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] shift_q, shift_nxt;
   logic [7:0] hi_byte, hi_nxt;
   logic       oe_nxt, busy_nxt, nack_nxt, commit;
   logic [2:0] scl_sync, sda_sync;
   logic [8:0] regfile [NUM_REGS];
   word_t      word_in;

   // [0] metastability stage, [1] synced level, [2] history for edge detect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], scl_in};
         sda_sync <= {sda_sync[1:0], sda_in};
      end
   end

   logic scl_cur, scl_prev, sda_cur, sda_prev;
   logic scl_rise, scl_fall, start_evt, stop_evt;

   assign scl_cur   = scl_sync[1];
   assign scl_prev  = scl_sync[2];
   assign sda_cur   = sda_sync[1];
   assign sda_prev  = sda_sync[2];
   assign scl_rise  = scl_cur & ~scl_prev;
   assign scl_fall  = ~scl_cur & scl_prev;
   assign start_evt = scl_cur & scl_prev & sda_prev & ~sda_cur;
   assign stop_evt  = scl_cur & scl_prev & ~sda_prev & sda_cur;

   assign word_in = {hi_byte, shift_q};
   assign rd_data = regfile[rd_addr];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_nxt = shift_q;
      hi_nxt    = hi_byte;
      oe_nxt    = sda_oe;
      busy_nxt  = busy;
      nack_nxt  = 1'b0;
      commit    = 1'b0;
      if (stop_evt) begin
         state_nxt = IDLE;
         oe_nxt    = 1'b0;
         busy_nxt  = 1'b0;
         cnt_nxt   = 4'd0;
      end else if (start_evt) begin
         state_nxt = ADDR;
         oe_nxt    = 1'b0;
         busy_nxt  = 1'b1;
         cnt_nxt   = 4'd0;
      end else begin
         case (state)
            IDLE: ;
            ADDR, BYTE1, BYTE2: begin
               if (scl_rise && cnt < 4'd8) begin
                  shift_nxt = {shift_q[6:0], sda_cur};
                  cnt_nxt   = cnt + 4'd1;
               end else if (scl_fall && cnt == 4'd8) begin
                  cnt_nxt = 4'd0;
                  if (state == ADDR) begin
                     if (shift_q == {DEV_ADDR, 1'b0}) begin
                        oe_nxt    = 1'b1;
                        state_nxt = ACK_A;
                     end else begin
                        // Keep the count at 8 so the pending 9th clock closes this byte
                        nack_nxt  = 1'b1;
                        cnt_nxt   = 4'd8;
                        state_nxt = IGNORE;
                     end
                  end else if (state == BYTE1) begin
                     hi_nxt    = shift_q;
                     oe_nxt    = 1'b1;
                     state_nxt = ACK_1;
                  end else begin
                     oe_nxt    = 1'b1;
                     commit    = 1'b1;
                     state_nxt = ACK_2;
                  end
               end
            end
            ACK_A, ACK_1, ACK_2: begin
               if (scl_fall) begin
                  oe_nxt  = 1'b0;
                  cnt_nxt = 4'd0;
                  state_nxt = (state == ACK_A) ? BYTE1 :
                              (state == ACK_1) ? BYTE2 : IGNORE;
               end
            end
            IGNORE: begin
               if (scl_rise) begin
                  cnt_nxt = cnt + 4'd1;
               end else if (scl_fall) begin
                  if (cnt == 4'd8) nack_nxt = 1'b1;
                  if (cnt == 4'd9) cnt_nxt = 4'd0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         shift_q  <= 8'd0;
         hi_byte  <= 8'd0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         nack_evt <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= 7'd0;
         wr_data  <= 9'd0;
         for (int i = 0; i < NUM_REGS; i++) regfile[i] <= 9'd0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         shift_q  <= shift_nxt;
         hi_byte  <= hi_nxt;
         sda_oe   <= oe_nxt;
         busy     <= busy_nxt;
         nack_evt <= nack_nxt;
         wr_valid <= commit;
         if (commit) begin
            wr_addr <= word_in.addr;
            wr_data <= word_in.data;
            if (word_in.addr == RST_REG) begin
               for (int i = 0; i < NUM_REGS; i++) regfile[i] <= 9'd0;
            end else if ({25'd0, word_in.addr} < NUM_REGS) begin
               regfile[word_in.addr[AW-1:0]] <= word_in.data;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master on a modelled open-drain bus plus a regfile model.
module tb_i2c_codec_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_m, sda_m;
   logic       scl_in, sda_in;
   logic       sda_oe, wr_valid, busy, nack_evt;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic [3:0] rd_addr;
   logic [8:0] rd_data;

   int n_total = 0, n_pass = 0, n_fail = 0;
   int wv_cnt = 0, nk_cnt = 0;
   logic [8:0] mregs [16];

   i2c_codec_responder dut (
      .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy), .nack_evt(nack_evt)
   );

   // Open-drain wired-AND of master and target
   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_valid) wv_cnt <= wv_cnt + 1;
      if (nack_evt) nk_cnt <= nk_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_commit(input logic [6:0] a, input logic [8:0] d);
      if (a == 7'h0F) begin
         for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
      end else if (a < 7'd16) begin
         mregs[a[3:0]] = d;
      end
   endfunction

   task automatic wait_q();
      repeat (8) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wait_q();
         scl_m = 1'b1; wait_q(); wait_q();
         scl_m = 1'b0; wait_q();
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      ack = ~sda_in;
      wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         @(negedge clk);
         check($sformatf("%s reg%0d", tag, i), {23'd0, rd_data}, {23'd0, mregs[i]});
      end
   endtask

   task automatic xfer_word(input logic [6:0] a, input logic [8:0] d, input string tag);
      logic [15:0] w;
      logic k0, k1, k2;
      int wv0;
      w = {a, d};
      wv0 = wv_cnt;
      bus_start();
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      write_byte(8'h34, k0);
      write_byte(w[15:8], k1);
      write_byte(w[7:0], k2);
      bus_stop();
      check({tag, " acks"}, {29'd0, k0, k1, k2}, 32'h7);
      check({tag, " wr_valid count"}, wv_cnt - wv0, 32'd1);
      check({tag, " wr_addr"}, {25'd0, wr_addr}, {25'd0, a});
      check({tag, " wr_data"}, {23'd0, wr_data}, {23'd0, d});
      check({tag, " busy after stop"}, {31'd0, busy}, 32'd0);
      model_commit(a, d);
      check_regs(tag);
   endtask

   initial begin
      logic k0, k1, k2, k3;
      logic [6:0] ra;
      logic [8:0] rdat;
      int wv0, nk0;

      reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
      for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
      repeat (4) @(negedge clk);
      check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
      check("reset wr_valid", {31'd0, wr_valid}, 32'd0);
      check("reset wr_addr", {25'd0, wr_addr}, 32'd0);
      check("reset wr_data", {23'd0, wr_data}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset nack_evt", {31'd0, nack_evt}, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_regs("reset");

      // Basic write 0x34,0x08,0x12
      xfer_word(7'h04, 9'h012, "w4");

      // Randomized writes, some to out-of-range addresses
      for (int n = 0; n < 10; n++) begin
         ra   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 14));
         rdat = 9'($urandom_range(0, 511));
         xfer_word(ra, rdat, $sformatf("rnd%0d", n));
      end

      // Preload reg 4 then clear the file via RST_REG
      xfer_word(7'h04, 9'h1A5, "preload");
      xfer_word(7'h0F, 9'h000, "clear");
      xfer_word(7'h02, 9'h0C3, "refill");

      // Foreign address
      wv0 = wv_cnt; nk0 = nk_cnt;
      bus_start();
      write_byte(8'h36, k0);
      check("addr36 ack", {31'd0, k0}, 32'd0);
      check("addr36 nack_evt", nk_cnt - nk0, 32'd1);
      check("addr36 busy held", {31'd0, busy}, 32'd1);
      bus_stop();
      check("addr36 busy after stop", {31'd0, busy}, 32'd0);
      check("addr36 no commit", wv_cnt - wv0, 32'd0);
      check_regs("addr36");

      // Read request
      wv0 = wv_cnt; nk0 = nk_cnt;
      bus_start();
      write_byte(8'h35, k0);
      bus_stop();
      check("read ack", {31'd0, k0}, 32'd0);
      check("read nack_evt", nk_cnt - nk0, 32'd1);
      check("read no commit", wv_cnt - wv0, 32'd0);

      // Partial word then STOP
      wv0 = wv_cnt;
      bus_start();
      write_byte(8'h34, k0);
      write_byte(8'h08, k1);
      bus_stop();
      check("partial acks", {30'd0, k0, k1}, 32'h3);
      check("partial no commit", wv_cnt - wv0, 32'd0);
      check_regs("partial");

      // Extra byte after a full word
      wv0 = wv_cnt; nk0 = nk_cnt;
      rdat = 9'($urandom_range(0, 511));
      bus_start();
      write_byte(8'h34, k0);
      write_byte({7'h07, rdat[8]}, k1);
      write_byte(rdat[7:0], k2);
      write_byte(8'($urandom_range(0, 255)), k3);
      bus_stop();
      check("4th byte acks", {28'd0, k0, k1, k2, k3}, 32'hE);
      check("4th byte nack_evt", nk_cnt - nk0, 32'd1);
      check("4th byte commit", wv_cnt - wv0, 32'd1);
      model_commit(7'h07, rdat);
      check_regs("4th byte");

      // Repeated START after byte 1
      wv0 = wv_cnt;
      bus_start();
      write_byte(8'h34, k0);
      write_byte(8'h08, k1);
      bus_start();
      check("rstart busy", {31'd0, busy}, 32'd1);
      write_byte(8'h34, k0);
      write_byte(8'h0A, k1);
      write_byte(8'h55, k2);
      bus_stop();
      check("rstart acks", {29'd0, k0, k1, k2}, 32'h7);
      check("rstart commit", wv_cnt - wv0, 32'd1);
      check("rstart wr_addr", {25'd0, wr_addr}, 32'h05);
      check("rstart wr_data", {23'd0, wr_data}, 32'h055);
      model_commit(7'h05, 9'h055);
      check_regs("rstart");

      // Reset while the address ACK is being driven
      bus_start();
      send_bits(8'h34);
      sda_m = 1'b1; wait_q();
      check("ack driven before reset", {31'd0, sda_oe}, 32'd1);
      reset = 1'b1;
      #1;
      check("reset mid sda_oe", {31'd0, sda_oe}, 32'd0);
      check("reset mid busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
      scl_m = 1'b1; sda_m = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_regs("reset mid");

      xfer_word(7'h09, 9'h101, "post reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
